// File: rtl/pll_cfg_ctrl.sv
// PLL configuration controller: sequences power-down, lock wait and run for a PLL macro
// and applies N/M updates only while the PLL is held in power-down.
// Optional build macro PLL_CFG_RANGE_CHECK_EN rejects out-of-range N/M requests with cfg_err.
module pll_cfg_ctrl #(
  parameter logic [7:0] DEF_N       = 8'd1,
  parameter logic [7:0] DEF_M       = 8'd10,
  parameter int         PDN_CYCLES  = 16,
  parameter int         LOCK_CYCLES = 4096
) (
  input  logic       osc_clk,
  input  logic       rst_n,
  input  logic       pll_en,
  input  logic       cfg_req,
  input  logic [7:0] cfg_n,
  input  logic [7:0] cfg_m,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic [7:0] pll_n,
  output logic [7:0] pll_m,
  output logic       pll_pdn,
  output logic       pll_ready,
  output logic       cfg_busy
);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    PDN_HOLD  = 2'd1,
    LOCK_WAIT = 2'd2,
    RUN       = 2'd3
  } state_t;

  // One counter serves both timed states, so it is sized for the longer of the two.
  localparam int CNT_MAX = (PDN_CYCLES > LOCK_CYCLES) ? PDN_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PDN_LOAD  = CNT_W'(PDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_done;
  logic             req_new;
  logic             req_take;
  logic             cfg_bad;
  logic             cfg_acc;

  // req_done remembers that the current held request was already answered, so a
  // requester that keeps cfg_req high across a restart is not acknowledged twice.
  assign req_new  = cfg_req && !req_done;
  assign req_take = req_new && ((state == OFF) || ((state == RUN) && pll_en));
  assign cfg_acc  = req_take && !cfg_bad;

`ifdef PLL_CFG_RANGE_CHECK_EN
  logic cfg_err_q;

  assign cfg_bad = (cfg_n[6:0] == 7'd0) || cfg_n[7] || (cfg_m[4:0] == 5'd0);
  assign cfg_err = cfg_err_q;

  always_ff @(posedge osc_clk) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= req_take && cfg_bad;
  end
`else
  assign cfg_bad = 1'b0;
  assign cfg_err = 1'b0;
`endif

  // NOTE: every register here uses <= so all of them see the pre-edge values of
  // state/cnt/inputs; a blocking = would let later lines see half-updated state.
  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      state     <= OFF;
      cnt       <= '0;
      req_done  <= 1'b0;
      cfg_ack   <= 1'b0;
      pll_n     <= DEF_N;
      pll_m     <= DEF_M;
      pll_pdn   <= 1'b0;
      pll_ready <= 1'b0;
      cfg_busy  <= 1'b0;
    end else begin
      cfg_ack <= cfg_acc;

      if (req_take)      req_done <= 1'b1;
      else if (!cfg_req) req_done <= 1'b0;

      if (cfg_acc) begin
        pll_n <= cfg_n;
        pll_m <= cfg_m;
      end

      if (!pll_en && (state != OFF)) begin
        state     <= OFF;
        cnt       <= '0;
        pll_pdn   <= 1'b0;
        pll_ready <= 1'b0;
        cfg_busy  <= 1'b0;
      end else begin
        unique case (state)
          OFF: begin
            // An answered request keeps the PLL off for this edge; pll_en is seen next cycle.
            if (!req_take && pll_en) begin
              state    <= PDN_HOLD;
              cnt      <= PDN_LOAD;
              cfg_busy <= 1'b1;
            end
          end
          PDN_HOLD: begin
            if (cnt == '0) begin
              state   <= LOCK_WAIT;
              cnt     <= LOCK_LOAD;
              pll_pdn <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LOCK_WAIT: begin
            if (cnt == '0) begin
              state     <= RUN;
              pll_ready <= 1'b1;
              cfg_busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RUN: begin
            if (cfg_acc) begin
              state     <= PDN_HOLD;
              cnt       <= PDN_LOAD;
              pll_pdn   <= 1'b0;
              pll_ready <= 1'b0;
              cfg_busy  <= 1'b1;
            end
          end
          default: begin
            state     <= OFF;
            cnt       <= '0;
            pll_pdn   <= 1'b0;
            pll_ready <= 1'b0;
            cfg_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Invariants of the PLL-facing interface.
  a_div_stable_while_running : assert property (
    @(posedge osc_clk) disable iff (!rst_n)
      pll_pdn |-> ($stable(pll_n) && $stable(pll_m))
  );

  a_ready_implies_running : assert property (
    @(posedge osc_clk) pll_ready |-> (pll_pdn && !cfg_busy)
  );

  a_ack_err_exclusive : assert property (
    @(posedge osc_clk) !(cfg_ack && cfg_err)
  );

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// Directed bench for pll_cfg_ctrl with PDN_CYCLES=4, LOCK_CYCLES=8; expected values are hand-derived.
// Build with +define+PLL_CFG_RANGE_CHECK_EN to exercise the range-check variant.
module tb_pll_cfg_ctrl;

  logic       osc_clk = 1'b0;
  logic       rst_n;
  logic       pll_en;
  logic       cfg_req;
  logic [7:0] cfg_n;
  logic [7:0] cfg_m;
  logic       cfg_ack;
  logic       cfg_err;
  logic [7:0] pll_n;
  logic [7:0] pll_m;
  logic       pll_pdn;
  logic       pll_ready;
  logic       cfg_busy;

  int n_vec  = 0;
  int n_miss = 0;

  pll_cfg_ctrl #(
    .DEF_N      (8'd1),
    .DEF_M      (8'd10),
    .PDN_CYCLES (4),
    .LOCK_CYCLES(8)
  ) dut (
    .osc_clk  (osc_clk),
    .rst_n    (rst_n),
    .pll_en   (pll_en),
    .cfg_req  (cfg_req),
    .cfg_n    (cfg_n),
    .cfg_m    (cfg_m),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .pll_n    (pll_n),
    .pll_m    (pll_m),
    .pll_pdn  (pll_pdn),
    .pll_ready(pll_ready),
    .cfg_busy (cfg_busy)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then sample at the following falling edge.
  task automatic step();
    @(posedge osc_clk);
    @(negedge osc_clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pdn"},   32'(pll_pdn),   32'd0);
    check({tag, "_ready"}, 32'(pll_ready), 32'd0);
    check({tag, "_ack"},   32'(cfg_ack),   32'd0);
    check({tag, "_err"},   32'(cfg_err),   32'd0);
    check({tag, "_busy"},  32'(cfg_busy),  32'd0);
    check({tag, "_n"},     32'(pll_n),     32'd1);
    check({tag, "_m"},     32'(pll_m),     32'd10);
  endtask

  // From OFF with pll_en=1: edge e=0 enters PDN_HOLD, pdn rises at e=4, ready at e=12.
  task automatic startup(input string tag, input logic [7:0] en, input logic [7:0] em);
    for (int e = 0; e <= 12; e++) begin
      step();
      check({tag, "_pdn"},   32'(pll_pdn),   32'(e >= 4));
      check({tag, "_ready"}, 32'(pll_ready), 32'(e >= 12));
      check({tag, "_busy"},  32'(cfg_busy),  32'(e < 12));
      check({tag, "_ack"},   32'(cfg_ack),   32'd0);
      check({tag, "_n"},     32'(pll_n),     32'(en));
      check({tag, "_m"},     32'(pll_m),     32'(em));
    end
  endtask

  initial begin
    int ack_j;
    int acks;

    rst_n   = 1'b0;
    pll_en  = 1'b0;
    cfg_req = 1'b0;
    cfg_n   = 8'd0;
    cfg_m   = 8'd0;
    @(negedge osc_clk);
    step();
    step();
    check_reset_state("rst");

    // Power-up from reset release with pll_en already high.
    rst_n  = 1'b1;
    pll_en = 1'b1;
    startup("boot", 8'd1, 8'd10);

    // Reconfigure from RUN: ack, immediate power-down, new dividers, ready after 12.
    cfg_req = 1'b1;
    cfg_n   = 8'd3;
    cfg_m   = 8'd20;
    step();
    check("rcfg_ack",   32'(cfg_ack),   32'd1);
    check("rcfg_ready", 32'(pll_ready), 32'd0);
    check("rcfg_pdn",   32'(pll_pdn),   32'd0);
    check("rcfg_busy",  32'(cfg_busy),  32'd1);
    check("rcfg_n",     32'(pll_n),     32'd3);
    check("rcfg_m",     32'(pll_m),     32'd20);
    cfg_req = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check("rcfg_wait_ack",   32'(cfg_ack),   32'd0);
      check("rcfg_wait_ready", 32'(pll_ready), 32'(e == 12));
      check("rcfg_wait_pdn",   32'(pll_pdn),   32'(e >= 4));
    end

    // Restart once more (n=5, m=7), then raise a held request during LOCK_WAIT.
    cfg_req = 1'b1;
    cfg_n   = 8'd5;
    cfg_m   = 8'd7;
    step();
    check("r2_ack", 32'(cfg_ack), 32'd1);
    cfg_req = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    check("lw_busy", 32'(cfg_busy), 32'd1);
    check("lw_pdn",  32'(pll_pdn),  32'd1);
    cfg_req = 1'b1;
    cfg_n   = 8'd9;
    cfg_m   = 8'd33;
    acks  = 0;
    ack_j = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (cfg_ack) begin
        acks++;
        ack_j = j;
      end
      if (j < 9) check("lw_hold_n", 32'(pll_n), 32'd5);
    end
    check("lw_ack_count", 32'(acks),  32'd1);
    check("lw_ack_cycle", 32'(ack_j), 32'd9);
    check("lw_new_n",     32'(pll_n), 32'd9);
    check("lw_new_m",     32'(pll_m), 32'd33);
    cfg_req = 1'b0;
    step();
    check("lw_ready_back", 32'(pll_ready), 32'd1);

    // pll_en low and cfg_req high together in RUN: pll_en wins, ack follows from OFF.
    pll_en  = 1'b0;
    cfg_req = 1'b1;
    cfg_n   = 8'd2;
    cfg_m   = 8'd12;
    step();
    check("prio_ack",   32'(cfg_ack),   32'd0);
    check("prio_pdn",   32'(pll_pdn),   32'd0);
    check("prio_ready", 32'(pll_ready), 32'd0);
    check("prio_n",     32'(pll_n),     32'd9);
    step();
    check("off_ack",  32'(cfg_ack),  32'd1);
    check("off_n",    32'(pll_n),    32'd2);
    check("off_m",    32'(pll_m),    32'd12);
    check("off_pdn",  32'(pll_pdn),  32'd0);
    check("off_busy", 32'(cfg_busy), 32'd0);
    cfg_req = 1'b0;
    step();
    check("off_ack_once", 32'(cfg_ack), 32'd0);

    // Abort at LOCK_WAIT count 3 (edge 8 after enable), then a full restart.
    pll_en = 1'b1;
    for (int e = 0; e <= 8; e++) step();
    check("abort_pre_pdn",  32'(pll_pdn),  32'd1);
    check("abort_pre_busy", 32'(cfg_busy), 32'd1);
    pll_en = 1'b0;
    step();
    check("abort_pdn",   32'(pll_pdn),   32'd0);
    check("abort_busy",  32'(cfg_busy),  32'd0);
    check("abort_ready", 32'(pll_ready), 32'd0);
    pll_en = 1'b1;
    startup("restart", 8'd2, 8'd12);

    // One-cycle reset while running.
    rst_n = 1'b0;
    step();
    check_reset_state("rst_run");
    rst_n = 1'b1;
    startup("post_rst", 8'd1, 8'd10);

    // Out-of-range request in RUN.
    cfg_req = 1'b1;
    cfg_n   = 8'd0;
    cfg_m   = 8'd5;
    step();
`ifdef PLL_CFG_RANGE_CHECK_EN
    check("range_err",   32'(cfg_err),   32'd1);
    check("range_ack",   32'(cfg_ack),   32'd0);
    check("range_ready", 32'(pll_ready), 32'd1);
    check("range_n",     32'(pll_n),     32'd1);
    check("range_m",     32'(pll_m),     32'd10);
`else
    check("range_err",   32'(cfg_err),   32'd0);
    check("range_ack",   32'(cfg_ack),   32'd1);
    check("range_ready", 32'(pll_ready), 32'd0);
    check("range_n",     32'(pll_n),     32'd0);
    check("range_m",     32'(pll_m),     32'd5);
`endif
    step();
    check("range_err_once", 32'(cfg_err), 32'd0);
    check("range_ack_once", 32'(cfg_ack), 32'd0);
    cfg_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
